// File: rtl/interrupt_controller_pkg.sv
// Shared constants and types for the interrupt controller: MMIO addresses,
// source bit indices, their dispatch vectors and the request FSM encoding.
package interrupt_controller_pkg;

  localparam logic [15:0] MMIO_IF = 16'hFF0F;
  localparam logic [15:0] MMIO_IE = 16'hFFFF;

  localparam int INT_VBLANK = 0;
  localparam int INT_STAT   = 1;
  localparam int INT_TIMER  = 2;
  localparam int INT_SERIAL = 3;
  localparam int INT_JOYPAD = 4;

  localparam logic [15:0] VEC_VBLANK = 16'h0040;
  localparam logic [15:0] VEC_STAT   = 16'h0048;
  localparam logic [15:0] VEC_TIMER  = 16'h0050;
  localparam logic [15:0] VEC_SERIAL = 16'h0058;
  localparam logic [15:0] VEC_JOYPAD = 16'h0060;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_DISPATCH = 2'd2
  } int_state_e;

  function automatic logic [15:0] calc_vector(input logic [15:0] base,
                                              input logic [15:0] stride,
                                              input logic [15:0] idx);
    logic [31:0] prod;
    prod = {16'd0, stride} * {16'd0, idx};
    return base + prod[15:0];
  endfunction

endpackage

// File: rtl/interrupt_controller_priority_enc.sv
// Lowest-set-bit encoder: bit 0 has the highest priority.
module int_priority_enc #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set bit is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: owns IF/IE, arbitrates sources by fixed priority and
// hands one request at a time to the CPU, clearing the serviced IF bit on ack.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_SRC       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0008
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        addr,
  inout  wire  [7:0]         data,
  input  logic               re_n,
  input  logic               we_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               ime,
  input  logic               int_ack,
  output logic               int_req,
  output logic [15:0]        int_vector,
  output logic               int_pending
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] if_reg, if_next;
  logic [7:0]         ie_reg, ie_next;
  int_state_e         state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [15:0]        vector_reg, vector_next;
  logic               int_req_reg;

  logic               sel_if, sel_ie;
  logic               wr_if, wr_ie;
  logic [NUM_SRC-1:0] pend;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic               ack_take;
  logic               rd_en;
  logic [7:0]         rd_data;

  assign sel_if = (addr == MMIO_IF);
  assign sel_ie = (addr == MMIO_IE);
  assign wr_if  = !we_n && sel_if;
  assign wr_ie  = !we_n && sel_ie;

  assign pend        = if_reg & ie_reg[NUM_SRC-1:0];
  assign int_pending = |pend;
  assign ack_take    = (state_reg == ST_REQUEST) && int_ack;

  int_priority_enc #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_priority_enc (
    .req   (pend),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Per-bit IF update: CPU write, then ack clear, then source set (source wins).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_if_bit
      logic ack_clr;
      logic base_val;
      assign ack_clr        = ack_take && (idx_reg == IDX_W'(gi));
      assign base_val       = wr_if ? data[gi] : if_reg[gi];
      assign if_next[gi]    = irq_src[gi] | (base_val & ~ack_clr);
    end
  endgenerate

  assign ie_next = wr_ie ? data : ie_reg;

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    vector_next = vector_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ime && win_valid) begin
          state_next  = ST_REQUEST;
          idx_next    = win_idx;
          vector_next = calc_vector(VECTOR_BASE, VECTOR_STRIDE, 16'(win_idx));
        end
      end
      ST_REQUEST: begin
        // The latched index is held; a higher-priority arrival waits its turn.
        if (int_ack) begin
          state_next = ST_DISPATCH;
        end else if (!pend[idx_reg] || !ime) begin
          state_next = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_reg      <= '0;
      ie_reg      <= '0;
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      vector_reg  <= '0;
      int_req_reg <= 1'b0;
    end else begin
      if_reg      <= if_next;
      ie_reg      <= ie_next;
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      vector_reg  <= vector_next;
      int_req_reg <= (state_next == ST_REQUEST);
    end
  end

  assign int_req    = int_req_reg;
  assign int_vector = vector_reg;

  // Unimplemented IF bits read back as ones.
  assign rd_data = sel_if ? {{(8 - NUM_SRC){1'b1}}, if_reg} : ie_reg;
  assign rd_en   = rst_n && !re_n && (sel_if || sel_ie);
  assign data    = rd_en ? rd_data : 8'hzz;

endmodule
